bus_responder_8227: RTL and testbench



---
 rtl/bus_responder_8227.sv | 247 ++++++++++++++++++++++++
 tb/tb_bus_responder_8227.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder_8227.sv
// bus_responder_8227: answers top8227 CPU bus cycles from SRAM (req/ack, 2-deep posted
// write FIFO), fixed vector bytes, and a 16-bit reload timer with a registered active-low IRQ.
// Ports: clk/nrst; CPU bus (cycleStrobe, address, readNotWrite, dataBusSelect,
// dataBusOutput -> dataBusInput, ready, interruptRequest); SRAM (sramReq/We/Addr/Wdata,
// sramRdata, sramAck).
module bus_responder_8227 #(
  parameter logic [15:0] RESET_VECTOR = 16'hF000,
  parameter logic [15:0] NMI_VECTOR   = 16'hF100,
  parameter logic [15:0] IRQ_VECTOR   = 16'hF200,
  parameter logic [15:0] RAM_TOP      = 16'h7FFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cycleStrobe,
  input  logic [7:0]  addressBusHigh,
  input  logic [7:0]  addressBusLow,
  input  logic        readNotWrite,
  input  logic        dataBusSelect,
  input  logic [7:0]  dataBusOutput,
  output logic [7:0]  dataBusInput,
  output logic        ready,
  output logic        interruptRequest,
  output logic        sramReq,
  output logic        sramWe,
  output logic [15:0] sramAddr,
  output logic [7:0]  sramWdata,
  input  logic [7:0]  sramRdata,
  input  logic        sramAck
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RD_REQ
  } state_t;

  state_t state, state_n;

  logic        strobe_d;
  logic [15:0] addr;
  logic        is_ram;
  logic        is_vec;
  logic        is_tmr;
  logic        cap_rd;
  logic        cap_wr;

  logic [15:0] fifo_addr [2];
  logic [7:0]  fifo_data [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        full;
  logic        push;
  logic        pop;
  logic        rd_done;
  logic [15:0] rd_addr;

  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic        tmr_en;
  logic        irq_en;
  logic        overrun;
  logic        flag;
  logic [15:0] counter;
  logic        flag_set;
  logic        tmr_wr;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        ovr_set;
  logic [7:0]  int_data;

  assign addr    = {addressBusHigh, addressBusLow};
  assign is_ram  = addr <= RAM_TOP;
  assign is_vec  = addr >= 16'hFFFA;
  assign is_tmr  = addr[15:2] == 14'h3400;

  // Reads are only taken while idle: a stalled CPU may re-strobe
  // the same read, which must not restart the SRAM access.
  assign cap_rd  = strobe_d & readNotWrite & (state == IDLE);
  assign cap_wr  = strobe_d & ~readNotWrite & ~dataBusSelect;

  assign full    = count == 2'd2;
  assign push    = cap_wr & is_ram & ~full;
  assign ovr_set = cap_wr & is_ram & full;
  assign pop     = sramAck & (state != RD_REQ) & (count != 2'd0);
  assign rd_done = sramAck & (state == RD_REQ);

  assign tmr_wr  = cap_wr & is_tmr;
  assign ctrl_wr = tmr_wr & (addr[1:0] == 2'd2);
  assign stat_wr = tmr_wr & (addr[1:0] == 2'd3);
  assign flag_set = tmr_en & (counter == 16'd0);

  always_comb begin
    int_data = 8'hFF;
    unique case (1'b1)
      is_vec: begin
        case (addr[2:0])
          3'd2:    int_data = NMI_VECTOR[7:0];
          3'd3:    int_data = NMI_VECTOR[15:8];
          3'd4:    int_data = RESET_VECTOR[7:0];
          3'd5:    int_data = RESET_VECTOR[15:8];
          3'd6:    int_data = IRQ_VECTOR[7:0];
          3'd7:    int_data = IRQ_VECTOR[15:8];
          default: int_data = 8'hFF;
        endcase
      end
      is_tmr: begin
        case (addr[1:0])
          2'd0:    int_data = reload_lo;
          2'd1:    int_data = reload_hi;
          2'd2:    int_data = {overrun, 5'd0, irq_en, tmr_en};
          default: int_data = {7'd0, flag};
        endcase
      end
      default: int_data = 8'hFF;
    endcase
  end

  // A pending read owns the port; otherwise the FIFO head is
  // presented whenever the FIFO holds data.
  always_comb begin
    sramReq   = 1'b0;
    sramWe    = 1'b0;
    sramAddr  = 16'd0;
    sramWdata = 8'd0;
    if (state == RD_REQ) begin
      sramReq  = 1'b1;
      sramAddr = rd_addr;
    end else if (count != 2'd0) begin
      sramReq   = 1'b1;
      sramWe    = 1'b1;
      sramAddr  = fifo_addr[rd_ptr];
      sramWdata = fifo_data[rd_ptr];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cap_rd && is_ram)
          state_n = (count != 2'd0) ? DRAIN : RD_REQ;
      end
      DRAIN: begin
        if (count == 2'd0)
          state_n = RD_REQ;
      end
      RD_REQ: begin
        if (sramAck)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      strobe_d     <= 1'b0;
      ready        <= 1'b1;
      dataBusInput <= 8'hFF;
      rd_addr      <= 16'd0;
    end else begin
      strobe_d <= cycleStrobe;
      if (cap_rd) begin
        if (is_ram) begin
          ready   <= 1'b0;
          rd_addr <= addr;
        end else begin
          dataBusInput <= int_data;
        end
      end else if (rd_done) begin
        dataBusInput <= sramRdata;
        ready        <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fifo_addr[0] <= 16'd0;
      fifo_addr[1] <= 16'd0;
      fifo_data[0] <= 8'd0;
      fifo_data[1] <= 8'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= addr;
        fifo_data[wr_ptr] <= dataBusOutput;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reload_lo        <= 8'd0;
      reload_hi        <= 8'd0;
      tmr_en           <= 1'b0;
      irq_en           <= 1'b0;
      overrun          <= 1'b0;
      flag             <= 1'b0;
      counter          <= 16'd0;
      interruptRequest <= 1'b1;
    end else begin
      if (tmr_wr && addr[1:0] == 2'd0)
        reload_lo <= dataBusOutput;
      if (tmr_wr && addr[1:0] == 2'd1)
        reload_hi <= dataBusOutput;
      if (ctrl_wr) begin
        tmr_en <= dataBusOutput[0];
        irq_en <= dataBusOutput[1];
      end
      if (ovr_set)
        overrun <= 1'b1;
      else if (ctrl_wr && dataBusOutput[7])
        overrun <= 1'b0;
      if (ctrl_wr && dataBusOutput[0])
        counter <= {reload_hi, reload_lo};
      else if (tmr_en)
        counter <= flag_set ? {reload_hi, reload_lo}
                            : counter - 16'd1;
      if (flag_set)
        flag <= 1'b1;
      else if (stat_wr && dataBusOutput[0])
        flag <= 1'b0;
      interruptRequest <= ~(flag & irq_en);
    end
  end

endmodule

// File: tb/tb_bus_responder_8227.sv
// tb_bus_responder_8227: randomized CPU bus traffic against a reference
// memory/vector model, SRAM responder model, and directed timer/reset cases.
module tb_bus_responder_8227;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cycleStrobe = 1'b0;
  logic [7:0]  addressBusHigh = 8'd0;
  logic [7:0]  addressBusLow = 8'd0;
  logic        readNotWrite = 1'b1;
  logic        dataBusSelect = 1'b1;
  logic [7:0]  dataBusOutput = 8'd0;
  logic [7:0]  dataBusInput;
  logic        ready;
  logic        interruptRequest;
  logic        sramReq;
  logic        sramWe;
  logic [15:0] sramAddr;
  logic [7:0]  sramWdata;
  logic [7:0]  sramRdata = 8'd0;
  logic        sramAck = 1'b0;

  bus_responder_8227 dut (
    .clk              (clk),
    .nrst             (nrst),
    .cycleStrobe      (cycleStrobe),
    .addressBusHigh   (addressBusHigh),
    .addressBusLow    (addressBusLow),
    .readNotWrite     (readNotWrite),
    .dataBusSelect    (dataBusSelect),
    .dataBusOutput    (dataBusOutput),
    .dataBusInput     (dataBusInput),
    .ready            (ready),
    .interruptRequest (interruptRequest),
    .sramReq          (sramReq),
    .sramWe           (sramWe),
    .sramAddr         (sramAddr),
    .sramWdata        (sramWdata),
    .sramRdata        (sramRdata),
    .sramAck          (sramAck)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // ---------------- SRAM device model ----------------
  logic [7:0]  sram_mem [logic [15:0]];
  logic [24:0] log_q [$];
  int          lat_min = 1;
  int          lat_max = 2;
  bit          hold = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic        cur_we;
  logic [15:0] cur_a;
  logic [7:0]  cur_d;

  always @(negedge clk) begin
    if (sramAck) sramAck = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        busy = 1'b0;
        sramAck = 1'b1;
        if (cur_we) sram_mem[cur_a] = cur_d;
        else sramRdata = sram_mem.exists(cur_a) ? sram_mem[cur_a]
                                                 : init_val(cur_a);
        log_q.push_back({cur_we, cur_a, cur_d});
      end
    end else if (sramReq && !hold) begin
      busy = 1'b1;
      cnt = $urandom_range(lat_max, lat_min);
      cur_we = sramWe;
      cur_a = sramAddr;
      cur_d = sramWdata;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    logic [15:0] v;
    if (a <= 16'h7FFF)
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    if (a >= 16'hFFFA) begin
      if (a <= 16'hFFFB) v = 16'hF100;
      else if (a <= 16'hFFFD) v = 16'hF000;
      else v = 16'hF200;
      return a[0] ? v[15:8] : v[7:0];
    end
    return 8'hFF;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       stall;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  bit   rd_wait = 1'b0;
  bit   saw_low = 1'b0;

  always @(negedge clk) begin
    if (rd_wait) begin
      if (!ready) saw_low = 1'b1;
      else begin
        mon_e = exp_q.pop_front();
        check("rd_data", dataBusInput, mon_e.data);
        check("rd_stall", saw_low, mon_e.stall);
        rd_wait = 1'b0;
      end
    end
  end

  // ---------------- CPU bus driver (call just after a negedge) -----
  task automatic strobe(input logic [15:0] a, input bit rnw,
                        input bit dsel, input logic [7:0] d);
    {addressBusHigh, addressBusLow} = a;
    readNotWrite = rnw;
    dataBusSelect = dsel;
    dataBusOutput = d;
    cycleStrobe = 1'b1;
    @(negedge clk);
    cycleStrobe = 1'b0;
    @(negedge clk);
    readNotWrite = 1'b1;
    dataBusSelect = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                           input bit track);
    strobe(a, 1'b0, 1'b0, d);
    if (track) ref_mem[a] = d;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] e);
    exp_t x;
    int n;
    x.data = e;
    x.stall = (a <= 16'h7FFF);
    exp_q.push_back(x);
    strobe(a, 1'b1, 1'b1, 8'h00);
    saw_low = 1'b0;
    rd_wait = 1'b1;
    n = 0;
    while (rd_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rd_wait) begin
      check("rd_timeout", rd_wait, 0);
      rd_wait = 1'b0;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    logic [15:0] a;
    int n;
    int t1;
    int t2;
    bit saw_high;

    repeat (3) @(negedge clk);
    check("rst_dbi", dataBusInput, 8'hFF);
    check("rst_ready", ready, 1);
    check("rst_irq", interruptRequest, 1);
    check("rst_req", sramReq, 0);
    check("rst_we", sramWe, 0);
    check("rst_addr", sramAddr, 16'h0000);
    check("rst_wdata", sramWdata, 8'h00);
    nrst = 1'b1;
    @(negedge clk);

    bus_read(16'hFFFC, 8'h00);
    bus_read(16'hFFFD, 8'hF0);
    bus_read(16'h9000, 8'hFF);
    bus_read(16'hFFFA, ref_read(16'hFFFA));
    bus_read(16'hFFFF, ref_read(16'hFFFF));

    // write then read with slow SRAM: write must reach SRAM first
    lat_min = 5;
    lat_max = 5;
    log_q.delete();
    bus_write(16'h0010, 8'h5A, 1);
    bus_read(16'h0010, 8'h5A);
    check("wr_rd_logsize", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("wr_first", log_q[0], {1'b1, 16'h0010, 8'h5A});
      check("rd_second", log_q[1][24:8], {1'b0, 16'h0010});
    end
    lat_min = 1;
    lat_max = 2;

    // write with dataBusSelect=1 is ignored
    strobe(16'h0020, 1'b0, 1'b1, 8'h77);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (sramReq) n++;
    end
    check("dsel_noreq", n, 0);
    bus_read(16'h0020, ref_read(16'h0020));

    // FIFO overflow with SRAM stalled
    hold = 1'b1;
    log_q.delete();
    bus_write(16'h0100, 8'h11, 1);
    bus_write(16'h0101, 8'h22, 1);
    bus_write(16'h0102, 8'h33, 0);
    check("ovf_req", sramReq, 1);
    check("ovf_head", sramAddr, 16'h0100);
    bus_read(16'hD002, 8'h80);
    hold = 1'b0;
    repeat (20) @(negedge clk);
    check("ovf_logsize", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("ovf_w0", log_q[0], {1'b1, 16'h0100, 8'h11});
      check("ovf_w1", log_q[1], {1'b1, 16'h0101, 8'h22});
    end
    bus_write(16'hD002, 8'h80, 0);
    bus_read(16'hD002, 8'h00);
    bus_read(16'h0102, ref_read(16'h0102));

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        a = 16'h0200 + 16'($urandom_range(0, 7));
        bus_write(a, 8'($urandom), 1);
      end else if (r < 75) begin
        a = 16'h0200 + 16'($urandom_range(0, 7));
        bus_read(a, ref_read(a));
      end else if (r < 85) begin
        a = 16'hFFFA + 16'($urandom_range(0, 5));
        bus_read(a, ref_read(a));
      end else begin
        if ($urandom_range(0, 1) == 1)
          a = 16'h8000 + 16'($urandom_range(0, 16'h4FFF));
        else
          a = 16'hE000 + 16'($urandom_range(0, 16'h1FF0));
        bus_read(a, ref_read(a));
      end
    end
    bus_read(16'hD002, 8'h00);

    // timer: reload 3 gives a 4-clk period
    bus_write(16'hD000, 8'h03, 0);
    bus_write(16'hD001, 8'h00, 0);
    bus_write(16'hD002, 8'h03, 0);
    n = 0;
    while (interruptRequest && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("irq_fall", interruptRequest, 0);
    t1 = cyc;
    strobe(16'hD003, 1'b0, 1'b0, 8'h01);
    saw_high = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (interruptRequest) saw_high = 1'b1;
      else if (saw_high) break;
    end
    t2 = cyc;
    check("irq_clear_high", saw_high, 1);
    check("irq_period", t2 - t1, 4);
    @(negedge clk);
    @(negedge clk);
    bus_read(16'hD000, 8'h03);
    bus_read(16'hD001, 8'h00);
    bus_read(16'hD002, 8'h03);

    // reload 0: flag sets every clk, so a clear never wins
    bus_write(16'hD000, 8'h00, 0);
    bus_write(16'hD002, 8'h03, 0);
    n = 0;
    strobe(16'hD003, 1'b0, 1'b0, 8'h01);
    repeat (8) begin
      @(negedge clk);
      if (interruptRequest) n++;
    end
    check("reload0_irq_held", n, 0);
    bus_write(16'hD002, 8'h00, 0);
    bus_write(16'hD003, 8'h01, 0);
    repeat (3) @(negedge clk);
    check("tmr_off_irq", interruptRequest, 1);
    bus_read(16'hD003, 8'h00);

    // reset during an outstanding SRAM read
    lat_min = 8;
    lat_max = 8;
    strobe(16'h0300, 1'b1, 1'b1, 8'h00);
    @(negedge clk);
    check("pend_req", sramReq, 1);
    check("pend_ready", ready, 0);
    nrst = 1'b0;
    #1;
    check("arst_req", sramReq, 0);
    check("arst_ready", ready, 1);
    check("arst_dbi", dataBusInput, 8'hFF);
    @(negedge clk);
    nrst = 1'b1;
    n = 0;
    repeat (14) begin
      @(negedge clk);
      if (sramReq || !ready || dataBusInput !== 8'hFF) n++;
    end
    check("late_ack_ignored", n, 0);
    lat_min = 1;
    lat_max = 2;
    bus_read(16'hFFFE, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
